// File: rtl/lot_gate_monitor_if.sv
// Sensor/status bundle for lot_gate_monitor: per-lane a/b sensors and clr in,
// per-lane enter/exit pulses plus occupancy status out.
interface lot_gate_monitor_if #(
  parameter int LANES = 2,
  parameter int CW    = 5
);
  logic [LANES-1:0] a;
  logic [LANES-1:0] b;
  logic             clr;
  logic [LANES-1:0] incr;
  logic [LANES-1:0] decr;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport slave (
    input  a, b, clr,
    output incr, decr, count, full, empty, overflow, underflow
  );

  modport master (
    output a, b, clr,
    input  incr, decr, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/lot_gate_monitor.sv
// Multi-lane parking gate monitor: per-lane direction FSMs feeding a shared
// saturating occupancy counter. Define LOT_SYNC_EN to add 2-flop sensor synchronisers.
module lot_gate_lane (
  input  logic clk,
  input  logic reset,
  input  logic i_a,
  input  logic i_b,
  output logic o_incr,
  output logic o_decr
);
  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3} state_t;

  state_t     r_state;
  logic       r_incr;
  logic       r_decr;
  logic [1:0] w_ab;

`ifdef LOT_SYNC_EN
  logic [1:0] r_a_s;
  logic [1:0] r_b_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_s <= '0;
      r_b_s <= '0;
    end else begin
      r_a_s <= {r_a_s[0], i_a};
      r_b_s <= {r_b_s[0], i_b};
    end
  end

  assign w_ab = {r_a_s[1], r_b_s[1]};
`else
  assign w_ab = {i_a, i_b};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_incr  <= 1'b0;
      r_decr  <= 1'b0;
    end else begin
      r_incr <= 1'b0;
      r_decr <= 1'b0;
      case (r_state)
        IDLE: if (w_ab == 2'b10) r_state <= EN1;
              else if (w_ab == 2'b01) r_state <= EX1;
        EN1:  if (w_ab == 2'b11) r_state <= EN2;
              else if (w_ab != 2'b10) r_state <= IDLE;
        EN2:  if (w_ab == 2'b01) r_state <= EN3;
              else if (w_ab == 2'b10) r_state <= EN1;
        EN3:  if (w_ab == 2'b00) begin
                r_state <= IDLE;
                r_incr  <= 1'b1;
              end else if (w_ab == 2'b11) r_state <= EN2;
        EX1:  if (w_ab == 2'b11) r_state <= EX2;
              else if (w_ab != 2'b01) r_state <= IDLE;
        EX2:  if (w_ab == 2'b10) r_state <= EX3;
              else if (w_ab == 2'b01) r_state <= EX1;
        EX3:  if (w_ab == 2'b00) begin
                r_state <= IDLE;
                r_decr  <= 1'b1;
              end else if (w_ab == 2'b11) r_state <= EX2;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_incr = r_incr;
  assign o_decr = r_decr;
endmodule

module lot_gate_monitor #(
  parameter int LANES    = 2,
  parameter int CAPACITY = 16,
  localparam int CW      = $clog2(CAPACITY + 1)
) (
  input  logic               clk,
  input  logic               reset,
  lot_gate_monitor_if.slave  bus
);
  // Wide enough that count+net never wraps for any lane count
  localparam int NW = CW + LANES + 1;
  localparam logic signed [NW-1:0] CAP_S = NW'(CAPACITY);
  localparam logic        [CW-1:0] CAP_U = CW'(CAPACITY);

  logic [LANES-1:0]        w_incr;
  logic [LANES-1:0]        w_decr;
  logic signed [NW-1:0]    w_net;
  logic signed [NW-1:0]    w_sum;
  logic [CW-1:0]           r_count;
  logic                    r_overflow;
  logic                    r_underflow;

  lot_gate_lane u_lane [LANES-1:0] (
    .clk    (clk),
    .reset  (reset),
    .i_a    (bus.a),
    .i_b    (bus.b),
    .o_incr (w_incr),
    .o_decr (w_decr)
  );

  always_comb begin
    w_net = '0;
    for (int i = 0; i < LANES; i++) begin
      w_net = w_net + $signed({{(NW-1){1'b0}}, w_incr[i]})
                    - $signed({{(NW-1){1'b0}}, w_decr[i]});
    end
    w_sum = $signed({{(NW-CW){1'b0}}, r_count}) + w_net;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.clr) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (w_sum > CAP_S) begin
      r_count    <= CAP_U;
      r_overflow <= 1'b1;
    end else if (w_sum[NW-1]) begin
      r_count     <= '0;
      r_underflow <= 1'b1;
    end else begin
      r_count <= w_sum[CW-1:0];
    end
  end

  assign bus.incr      = w_incr;
  assign bus.decr      = w_decr;
  assign bus.count     = r_count;
  assign bus.full      = (r_count == CAP_U);
  assign bus.empty     = (r_count == '0);
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_lot_gate_monitor.sv
// Directed bench for lot_gate_monitor (LANES=2, CAPACITY=16, default build).
module tb_lot_gate_monitor;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  lot_gate_monitor_if #(.LANES(2), .CW(5)) bus ();

  lot_gate_monitor #(.LANES(2), .CAPACITY(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] ab0, input logic [1:0] ab1);
    bus.a = {ab1[1], ab0[1]};
    bus.b = {ab1[0], ab0[0]};
    @(posedge clk);
    #1;
  endtask

  // kind: 0 idle, 1 entry (10,11,01,00), 2 exit (01,11,10,00)
  function automatic logic [1:0] pat(input int kind, input int s);
    logic [1:0] p;
    p = 2'b00;
    if (kind == 1) p = (s == 0) ? 2'b10 : (s == 1) ? 2'b11 : (s == 2) ? 2'b01 : 2'b00;
    if (kind == 2) p = (s == 0) ? 2'b01 : (s == 1) ? 2'b11 : (s == 2) ? 2'b10 : 2'b00;
    return p;
  endfunction

  task automatic run(input int k0, input int k1);
    for (int s = 0; s < 4; s++) cyc(pat(k0, s), pat(k1, s));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.a = '0;
    bus.b = '0;
    bus.clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;

    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_unf", 32'(bus.underflow), 0);
    chk("rst_incr", 32'(bus.incr), 0);
    chk("rst_decr", 32'(bus.decr), 0);
    @(negedge clk) reset = 1'b0;

    // single entry on lane 0
    run(1, 0);
    chk("ent_incr", 32'(bus.incr), 32'h1);
    chk("ent_cnt_lag", 32'(bus.count), 0);
    chk("ent_empty_lag", 32'(bus.empty), 1);
    cyc(2'b00, 2'b00);
    chk("ent_incr_drop", 32'(bus.incr), 0);
    chk("ent_count", 32'(bus.count), 1);
    chk("ent_empty", 32'(bus.empty), 0);
    run(1, 0); cyc(2'b00, 2'b00);
    chk("ent2_count", 32'(bus.count), 2);

    // two exits on lane 1
    run(0, 2);
    chk("ex1_decr", 32'(bus.decr), 32'h2);
    chk("ex1_incr", 32'(bus.incr), 0);
    cyc(2'b00, 2'b00);
    chk("ex1_count", 32'(bus.count), 1);
    run(0, 2);
    chk("ex2_decr", 32'(bus.decr), 32'h2);
    cyc(2'b00, 2'b00);
    chk("ex2_count", 32'(bus.count), 0);
    chk("ex2_empty", 32'(bus.empty), 1);
    chk("ex2_unf", 32'(bus.underflow), 0);

    // pedestrian and reversal
    cyc(2'b10, 2'b00); cyc(2'b00, 2'b00);
    chk("ped_incr", 32'(bus.incr), 0);
    cyc(2'b00, 2'b00);
    chk("ped_incr2", 32'(bus.incr), 0);
    cyc(2'b10, 2'b00); cyc(2'b11, 2'b00); cyc(2'b10, 2'b00); cyc(2'b00, 2'b00);
    chk("rev_pulse", 32'({bus.incr, bus.decr}), 0);
    cyc(2'b00, 2'b00);
    chk("rev_pulse2", 32'({bus.incr, bus.decr}), 0);
    chk("rev_count", 32'(bus.count), 0);

    // build to 5, then simultaneous entry/exit
    for (int n = 0; n < 5; n++) begin run(1, 0); cyc(2'b00, 2'b00); end
    chk("five_count", 32'(bus.count), 5);
    run(1, 2);
    chk("sim_incr", 32'(bus.incr), 32'h1);
    chk("sim_decr", 32'(bus.decr), 32'h2);
    cyc(2'b00, 2'b00);
    chk("sim_count", 32'(bus.count), 5);

    // fill to capacity with paired entries, then overflow
    for (int n = 0; n < 5; n++) begin run(1, 1); cyc(2'b00, 2'b00); end
    chk("pair_count", 32'(bus.count), 15);
    chk("pair_full", 32'(bus.full), 0);
    run(1, 0); cyc(2'b00, 2'b00);
    chk("cap_count", 32'(bus.count), 16);
    chk("cap_full", 32'(bus.full), 1);
    chk("cap_ovf", 32'(bus.overflow), 0);
    run(1, 0); cyc(2'b00, 2'b00);
    chk("ovf_count", 32'(bus.count), 16);
    chk("ovf_full", 32'(bus.full), 1);
    chk("ovf_flag", 32'(bus.overflow), 1);

    bus.clr = 1'b1; cyc(2'b00, 2'b00); bus.clr = 1'b0;
    chk("clr_count", 32'(bus.count), 0);
    chk("clr_ovf", 32'(bus.overflow), 0);
    chk("clr_full", 32'(bus.full), 0);
    chk("clr_empty", 32'(bus.empty), 1);

    // pulse landing in a clr cycle is dropped
    run(1, 0);
    chk("clrp_incr", 32'(bus.incr), 32'h1);
    bus.clr = 1'b1; cyc(2'b00, 2'b00); bus.clr = 1'b0;
    chk("clrp_count", 32'(bus.count), 0);
    cyc(2'b00, 2'b00);
    chk("clrp_count2", 32'(bus.count), 0);

    // underflow on exit from empty
    run(0, 2); cyc(2'b00, 2'b00);
    chk("unf_count", 32'(bus.count), 0);
    chk("unf_flag", 32'(bus.underflow), 1);
    run(1, 0); cyc(2'b00, 2'b00);
    chk("unf_sticky", 32'(bus.underflow), 1);
    chk("unf_count1", 32'(bus.count), 1);

    // async reset mid-entry (lane 0 in EN2)
    cyc(2'b10, 2'b00); cyc(2'b11, 2'b00);
    #2 reset = 1'b1;
    #1;
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_empty", 32'(bus.empty), 1);
    chk("arst_unf", 32'(bus.underflow), 0);
    chk("arst_incr", 32'(bus.incr), 0);
    @(negedge clk) reset = 1'b0;
    cyc(2'b01, 2'b00);
    chk("arst_p1", 32'({bus.incr, bus.decr}), 0);
    cyc(2'b00, 2'b00);
    chk("arst_p2", 32'({bus.incr, bus.decr}), 0);
    cyc(2'b00, 2'b00);
    chk("arst_p3", 32'({bus.incr, bus.decr}), 0);
    chk("arst_count2", 32'(bus.count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
